// File: rtl/dac_chain_spi.sv
// SPI master that shifts NUM_CH command words through a daisy chain of DACs in one csel frame.
// Optional readback (miso capture per channel) is built when DAC_CHAIN_READBACK_EN is defined.
module dac_chain_spi #(
  parameter int NUM_CH  = 4,
  parameter int WORD_W  = 32,
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              trig,
  input  logic [WORD_W-1:0] word,
  output logic [ADDR_W-1:0] addr,
  output logic              sclk,
  output logic              csel,
  output logic              mosi,
  output logic              busy,
  output logic              flush,
  output logic              done
`ifdef DAC_CHAIN_READBACK_EN
  ,
  input  logic              miso,
  output logic [WORD_W-1:0] rdata,
  output logic [ADDR_W-1:0] rdata_ch,
  output logic              rdata_valid
`endif
);
  localparam int TOTAL = NUM_CH * WORD_W;
  localparam int BIT_W = $clog2(TOTAL) + 1;
  localparam int WB_W  = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(TOTAL - 1);
  localparam logic [WB_W-1:0]   LAST_WB   = WB_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_CH   = ADDR_W'(NUM_CH - 1);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]        HOLD_LAST = 8'(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        div_reg, div_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [WB_W-1:0]   wbit_reg, wbit_next;
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              sclk_reg, sclk_next;
  logic              flush_reg, flush_next;
  logic              done_reg, done_next;
  logic              pending_reg, pending_next;
  logic              gap_half_reg, gap_half_next;
  logic              div_tick, sclk_rise, sclk_fall, word_end;

  assign div_tick  = (div_reg == DIV_LAST);
  assign sclk_rise = (state_reg == SHIFT) && div_tick && !sclk_reg;
  assign sclk_fall = (state_reg == SHIFT) && div_tick && sclk_reg;
  assign word_end  = (wbit_reg == LAST_WB);

  always_ff @(posedge clkin) begin
    if (!reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      wbit_reg     <= '0;
      shreg_reg    <= '0;
      addr_reg     <= '0;
      sclk_reg     <= 1'b0;
      flush_reg    <= 1'b0;
      done_reg     <= 1'b0;
      pending_reg  <= 1'b0;
      gap_half_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      wbit_reg     <= wbit_next;
      shreg_reg    <= shreg_next;
      addr_reg     <= addr_next;
      sclk_reg     <= sclk_next;
      flush_reg    <= flush_next;
      done_reg     <= done_next;
      pending_reg  <= pending_next;
      gap_half_reg <= gap_half_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    bit_next      = bit_reg;
    wbit_next     = wbit_reg;
    shreg_next    = shreg_reg;
    addr_next     = addr_reg;
    sclk_next     = sclk_reg;
    flush_next    = 1'b0;
    done_next     = 1'b0;
    gap_half_next = gap_half_reg;
    pending_next  = pending_reg | (trig && (state_reg != IDLE));
    case (state_reg)
      IDLE: begin
        sclk_next = 1'b0;
        addr_next = '0;
        if (trig || pending_reg) begin
          state_next   = SHIFT;
          shreg_next   = word;
          flush_next   = 1'b1;
          pending_next = 1'b0;
          div_next     = '0;
          bit_next     = '0;
          wbit_next    = '0;
        end
      end
      SHIFT: begin
        div_next = div_tick ? 8'd0 : div_reg + 8'd1;
        if (div_tick) sclk_next = !sclk_reg;
        // Advance addr early so the next word is on the memory bus by the following fall.
        if (sclk_rise && word_end && (addr_reg != LAST_CH)) addr_next = addr_reg + ADDR_W'(1);
        if (sclk_fall) begin
          if (bit_reg == LAST_BIT) begin
            state_next = HOLD;
            shreg_next = '0;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
            if (word_end) begin
              shreg_next = word;
              flush_next = 1'b1;
              wbit_next  = '0;
            end else begin
              shreg_next = {shreg_reg[WORD_W-2:0], 1'b0};
              wbit_next  = wbit_reg + WB_W'(1);
            end
          end
        end
      end
      HOLD: begin
        // The cycle of the last fall counts as the first HOLD cycle.
        if (div_reg == HOLD_LAST) begin
          state_next    = GAP;
          done_next     = 1'b1;
          addr_next     = '0;
          div_next      = '0;
          gap_half_next = 1'b0;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      GAP: begin
        if (div_tick) begin
          div_next = '0;
          if (gap_half_reg) state_next = IDLE;
          else gap_half_next = 1'b1;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr  = addr_reg;
  assign sclk  = sclk_reg;
  assign csel  = !((state_reg == SHIFT) || (state_reg == HOLD));
  assign mosi  = (state_reg == SHIFT) && shreg_reg[WORD_W-1];
  assign busy  = (state_reg != IDLE);
  assign flush = flush_reg;
  assign done  = done_reg;

`ifdef DAC_CHAIN_READBACK_EN
  logic [WORD_W-1:0] rx_reg, rdata_reg;
  logic [ADDR_W-1:0] rx_ch_reg, rdata_ch_reg;
  logic              rx_last_reg, rdata_valid_reg;

  always_ff @(posedge clkin) begin
    if (!reset) begin
      rx_reg          <= '0;
      rx_ch_reg       <= '0;
      rx_last_reg     <= 1'b0;
      rdata_reg       <= '0;
      rdata_ch_reg    <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      rx_last_reg     <= sclk_rise && word_end;
      rdata_valid_reg <= rx_last_reg;
      if (sclk_rise) begin
        rx_reg    <= {rx_reg[WORD_W-2:0], miso};
        rx_ch_reg <= addr_reg;
      end
      if (rx_last_reg) begin
        rdata_reg    <= rx_reg;
        rdata_ch_reg <= rx_ch_reg;
      end
    end
  end

  assign rdata       = rdata_reg;
  assign rdata_ch    = rdata_ch_reg;
  assign rdata_valid = rdata_valid_reg;
`endif
endmodule

// File: doc/dac_chain_spi.md
DAC_CHAIN_SPI -- requirements
Module: dac_chain_spi

Interface
REQ-001 Parameter NUM_CH, default 4: number of daisy-chained DACs; legal range 1-16.
REQ-002 Parameter WORD_W, default 32: bits per DAC command word; legal range 8-32.
REQ-003 Parameter CLK_DIV, default 1: sclk half-period in clkin cycles; legal range 1-255.
REQ-004 Parameter ADDR_W, default 4: width of addr; 2^ADDR_W SHALL be at least NUM_CH.
REQ-005 clkin  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 trig  in  1  transfer request, level-sampled each clkin edge.
REQ-008 word  in  WORD_W  command word read from external memory at addr.
REQ-009 addr  out  ADDR_W  registered channel index of the word being fetched.
REQ-010 sclk  out  1  serial clock to the DACs.
REQ-011 csel  out  1  active-low chip select framing the whole chain.
REQ-012 mosi  out  1  serial data, MSB first.
REQ-013 busy  out  1  high from transfer start until the inter-frame gap ends.
REQ-014 flush  out  1  one-cycle pulse when word[addr] is captured, so memory can reset that entry to NOP.
REQ-015 done  out  1  one-cycle pulse in the cycle csel rises.

Function
REQ-016 The state machine SHALL have four states: IDLE, SHIFT, HOLD, GAP. Any illegal encoding SHALL go to IDLE.
REQ-017 IDLE: csel=1, sclk=0, mosi=0, addr=0, busy=0. If trig=1 or pending=1, the next edge SHALL set csel=0, capture word (channel 0), pulse flush, and enter SHIFT.
REQ-018 SHIFT: sclk SHALL toggle every CLK_DIV cycles, starting low. The first rise comes CLK_DIV cycles after csel falls.
REQ-019 mosi SHALL equal shreg[WORD_W-1]. On each falling sclk, shreg SHALL shift left by 1 with zero fill.
REQ-020 Channels SHALL go out in addr order 0..NUM_CH-1. Channel 0 reaches the farthest DAC.
REQ-021 addr SHALL increment on the rising sclk of the last bit of channel k (k<NUM_CH-1).
REQ-022 The following falling sclk SHALL load shreg with word instead of shifting, and pulse flush with addr=k+1.
REQ-023 After NUM_CH*WORD_W sclk periods, at the last falling sclk: enter HOLD, sclk stays 0, mosi=0.
REQ-024 HOLD SHALL keep csel=0 for CLK_DIV cycles. Then csel=1, done pulses, addr=0, and the block enters GAP.
REQ-025 GAP SHALL keep csel=1 and busy=1 for 2*CLK_DIV cycles, then return to IDLE.
REQ-026 trig=1 in any state other than IDLE SHALL set the one-deep pending flag. Additional trigs while pending=1 are merged.
REQ-027 pending SHALL clear when a transfer starts.
REQ-028 trig held high continuously SHALL produce back-to-back frames separated by exactly 2*CLK_DIV+1 csel-high cycles.
REQ-029 Bit counter width SHALL be clog2(NUM_CH*WORD_W)+1. The divider counter width SHALL be 8. No counter SHALL wrap during a frame.
REQ-030 addr bits above the channel index SHALL be 0.

Reset
REQ-031 On the reset=0 edge: state=IDLE, csel=1, sclk=0, mosi=0, addr=0, busy=0, flush=0, done=0, pending=0, shreg=0, counters=0.
REQ-032 Reset mid-frame SHALL abort the frame; csel rises on that same edge, and done SHALL NOT pulse.

Configuration
REQ-033 With DAC_CHAIN_READBACK_EN defined, the block SHALL add these ports:
- miso (in, 1)
- rdata (out, WORD_W)
- rdata_ch (out, ADDR_W)
- rdata_valid (out, 1)
REQ-034 With DAC_CHAIN_READBACK_EN defined, miso SHALL be sampled on each rising sclk into a WORD_W shift register, MSB first.
REQ-035 With DAC_CHAIN_READBACK_EN defined, rdata_valid SHALL pulse one cycle after each channel's last rising sclk, with rdata_ch=channel index. rdata/rdata_valid reset to 0.
REQ-036 Without DAC_CHAIN_READBACK_EN, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-037 Defaults, memory = {0x00300001, 0x00300002, 0x00300003, 0x00300004}, trig pulse 1 cycle at T0:
- csel low T1..T258
- 128 sclk rises
- mosi decodes the words in addr order
- done at T259
- busy low at T261
REQ-038 CLK_DIV=3, NUM_CH=2, WORD_W=24:
- sclk high/low 3 cycles each
- 48 rises
- csel low 3 cycles after the last fall
- flush pulses exactly twice, addr 0 then 1
REQ-039 Defaults, second trig mid-frame plus a third trig:
- exactly one extra frame follows
- csel high for exactly 3 cycles between frames
REQ-040 Defaults, reset=0 for 1 cycle at the 40th sclk rise:
- next edge csel=1, sclk=0, mosi=0
- no done pulse
- a later trig gives a complete, correct frame
REQ-041 With DAC_CHAIN_READBACK_EN, miso looped from mosi delayed by 32 bits:
- rdata_valid pulses 4 times
- rdata_ch = 0..3
- rdata for channels 1..3 equals words 0..2
